// File: rtl/soc_bus_pkg.sv
// Shared definitions for the single-master SoC bus fabric: FSM encoding,
// default address map and index-width helper.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int MAX_SLAVES = 16;

  // Default map: slave0 ROM, slave1 RAM, slave2 port block, slave3 timer
  localparam logic [4*32-1:0] DEFAULT_BASE =
    {32'hF1000000, 32'hF0000000, 32'h00010000, 32'h00000000};
  localparam logic [4*32-1:0] DEFAULT_MASK =
    {32'hFFFFFFF8, 32'hFFFFFFF0, 32'hFFFF0000, 32'hFFFF0000};

  // clog2 with a floor of one bit so a single-slave build still has an index
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/soc_bus_decoder.sv
// Table-driven base/mask address decoder; the lowest-numbered matching slave wins.
module soc_bus_decoder
  import soc_bus_pkg::*;
#(
  parameter int                        NUM_SLAVES = 4,
  parameter int                        IDX_W      = 2,
  parameter logic [NUM_SLAVES*32-1:0]  SLAVE_BASE = DEFAULT_BASE,
  parameter logic [NUM_SLAVES*32-1:0]  SLAVE_MASK = DEFAULT_MASK
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so a lower index overwrites any higher match
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/soc_bus_fabric.sv
// Single-master bus fabric: decodes the CPU request, runs one slave access with
// wait states and a timeout, and returns a registered response with error logging.
module soc_bus_fabric
  import soc_bus_pkg::*;
#(
  parameter int                        NUM_SLAVES = 4,
  parameter int                        DATA_W     = 32,
  parameter logic [NUM_SLAVES*32-1:0]  SLAVE_BASE = DEFAULT_BASE,
  parameter logic [NUM_SLAVES*32-1:0]  SLAVE_MASK = DEFAULT_MASK,
  parameter int                        TIMEOUT    = 15,
  parameter logic [15:0]               ERR_MAX    = 16'hFFFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cpu_valid,
  input  logic                         cpu_instr,
  input  logic                         cpu_write,
  input  logic [31:0]                  cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_ready,
  output logic                         cpu_error,
  output logic [NUM_SLAVES-1:0]        slv_sel,
  output logic                         slv_write,
  output logic                         slv_instr,
  output logic [31:0]                  slv_addr,
  output logic [DATA_W-1:0]            slv_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]        slv_ready,
  output logic [31:0]                  err_addr,
  output logic [15:0]                  err_count
);

  localparam int         IDX_W    = idx_width(NUM_SLAVES);
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t              state;
  logic                dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic [IDX_W-1:0]    idx;
  logic [7:0]          wait_cnt;
  logic                ready_sel;
  logic [DATA_W-1:0]   rdata_sel;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v >= ERR_MAX) ? v : v + 16'd1;
  endfunction

  soc_bus_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (IDX_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decoder (
    .addr (cpu_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  // Only the latched slave's handshake and data are observed
  assign ready_sel = slv_ready[idx];
  assign rdata_sel = slv_rdata[idx*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      wait_cnt  <= '0;
      slv_sel   <= '0;
      slv_write <= 1'b0;
      slv_instr <= 1'b0;
      slv_addr  <= '0;
      slv_wdata <= '0;
      cpu_ready <= 1'b0;
      cpu_error <= 1'b0;
      cpu_rdata <= '0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_valid) begin
            slv_addr  <= cpu_addr;
            slv_wdata <= cpu_wdata;
            slv_instr <= cpu_instr;
            idx       <= dec_idx;
            wait_cnt  <= '0;
            if (dec_hit) begin
              state     <= ST_ACCESS;
              slv_sel   <= NUM_SLAVES'(1) << dec_idx;
              slv_write <= cpu_write;
            end else begin
              state     <= ST_RESP;
              cpu_ready <= 1'b1;
              cpu_error <= 1'b1;
              cpu_rdata <= '0;
              err_addr  <= cpu_addr;
              err_count <= sat_inc(err_count);
            end
          end
        end

        ST_ACCESS: begin
          if (ready_sel) begin
            state     <= ST_RESP;
            cpu_ready <= 1'b1;
            cpu_error <= 1'b0;
            cpu_rdata <= slv_write ? '0 : rdata_sel;
            slv_sel   <= '0;
            slv_write <= 1'b0;
          end else if (wait_cnt == LAST_CNT) begin
            state     <= ST_RESP;
            cpu_ready <= 1'b1;
            cpu_error <= 1'b1;
            cpu_rdata <= '0;
            slv_sel   <= '0;
            slv_write <= 1'b0;
            err_addr  <= slv_addr;
            err_count <= sat_inc(err_count);
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        ST_RESP: begin
          // Response is held until the CPU withdraws its request
          if (!cpu_valid) begin
            state     <= ST_IDLE;
            cpu_ready <= 1'b0;
            cpu_error <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed bench for soc_bus_fabric: default-map instance plus a small
// overlapping-map instance with a low error ceiling.
module tb_soc_bus_fabric;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         cpu_valid, cpu_instr, cpu_write;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_ready, cpu_error;
  logic [3:0]   slv_sel;
  logic         slv_write, slv_instr;
  logic [31:0]  slv_addr, slv_wdata, err_addr;
  logic [127:0] slv_rdata;
  logic [3:0]   slv_ready;
  logic [15:0]  err_count;

  soc_bus_fabric dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_valid (cpu_valid),
    .cpu_instr (cpu_instr),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_error (cpu_error),
    .slv_sel   (slv_sel),
    .slv_write (slv_write),
    .slv_instr (slv_instr),
    .slv_addr  (slv_addr),
    .slv_wdata (slv_wdata),
    .slv_rdata (slv_rdata),
    .slv_ready (slv_ready),
    .err_addr  (err_addr),
    .err_count (err_count)
  );

  // Second instance: slave0 and slave1 overlap, error counter tops out at 3
  logic         o_valid;
  logic [31:0]  o_addr, o_rdata, o_slv_addr, o_slv_wdata, o_err_addr;
  logic         o_ready, o_error, o_slv_write, o_slv_instr;
  logic [1:0]   o_slv_sel;
  logic [63:0]  o_slv_rdata;
  logic [1:0]   o_slv_ready;
  logic [15:0]  o_err_count;

  soc_bus_fabric #(
    .NUM_SLAVES (2),
    .DATA_W     (32),
    .SLAVE_BASE ({32'h00000000, 32'h00000000}),
    .SLAVE_MASK ({32'hFFF00000, 32'hFFFF0000}),
    .TIMEOUT    (4),
    .ERR_MAX    (16'd3)
  ) dut_ovl (
    .clk       (clk),
    .reset     (reset),
    .cpu_valid (o_valid),
    .cpu_instr (1'b0),
    .cpu_write (1'b0),
    .cpu_addr  (o_addr),
    .cpu_wdata (32'h0),
    .cpu_rdata (o_rdata),
    .cpu_ready (o_ready),
    .cpu_error (o_error),
    .slv_sel   (o_slv_sel),
    .slv_write (o_slv_write),
    .slv_instr (o_slv_instr),
    .slv_addr  (o_slv_addr),
    .slv_wdata (o_slv_wdata),
    .slv_rdata (o_slv_rdata),
    .slv_ready (o_slv_ready),
    .err_addr  (o_err_addr),
    .err_count (o_err_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave responder: selected slave raises ready after wait_cfg[i] access cycles
  int  wait_cfg [4];
  bit  stray;
  int  acc_cnt, sel_cyc, wr_cyc;

  initial begin
    slv_ready = '0;
    acc_cnt   = 0;
    forever begin
      @(negedge clk);
      slv_ready = {4{stray}};
      if (slv_sel != 4'b0000) begin
        for (int i = 0; i < 4; i++)
          if (slv_sel[i]) slv_ready[i] = (acc_cnt >= wait_cfg[i]);
        acc_cnt++;
        sel_cyc++;
        if (slv_write) wr_cyc++;
      end else begin
        acc_cnt = 0;
      end
    end
  end

  int          lat;
  logic [3:0]  sel1, sel_resp;
  logic [31:0] addr1, wdata1, rdata;
  logic        err, held, dropped;

  task automatic do_txn(input logic [31:0] a, input logic w, input logic [31:0] wd);
    sel_cyc = 0; wr_cyc = 0; lat = -1;
    cpu_addr = a; cpu_write = w; cpu_wdata = wd; cpu_instr = 1'b1; cpu_valid = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        sel1 = slv_sel; addr1 = slv_addr; wdata1 = slv_wdata;
        cpu_addr = 32'hFFFF_FFFC; cpu_wdata = ~wd; cpu_write = ~w; cpu_instr = 1'b0;
      end
      if (cpu_ready) begin
        lat = c;
        break;
      end
    end
    rdata = cpu_rdata; err = cpu_error; sel_resp = slv_sel;
    @(posedge clk); #1; held = cpu_ready;
    cpu_valid = 1'b0;
    @(posedge clk); #1; dropped = cpu_ready;
    @(posedge clk); #1;
  endtask

  int          o_lat;
  logic [1:0]  o_sel1;
  logic [31:0] o_rd;
  logic        o_er;

  task automatic o_txn(input logic [31:0] a);
    o_addr = a; o_valid = 1'b1; o_lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) o_sel1 = o_slv_sel;
      if (o_ready) begin
        o_lat = c;
        break;
      end
    end
    o_rd = o_rdata; o_er = o_error;
    o_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; stray = 1'b0;
    cpu_valid = 1'b0; cpu_instr = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 4; i++) wait_cfg[i] = 0;
    slv_rdata = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
    o_valid = 1'b0; o_addr = '0;
    o_slv_ready = 2'b11;
    o_slv_rdata = {32'hBBBB0001, 32'hAAAA0000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {cpu_ready, cpu_error, slv_write, slv_instr, slv_sel}, 8'h00);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_slv_addr", slv_addr, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_err_count", err_count, 16'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Zero-wait read from slave0
    do_txn(32'h0000_0010, 1'b0, 32'h0);
    chk("rd0_latency", lat, 2);
    chk("rd0_sel", sel1, 4'b0001);
    chk("rd0_addr", addr1, 32'h0000_0010);
    chk("rd0_rdata", rdata, 32'hDEADBEEF);
    chk("rd0_error", err, 1'b0);
    chk("rd0_sel_after", sel_resp, 4'b0000);
    chk("rd0_ready_held", held, 1'b1);
    chk("rd0_ready_drop", dropped, 1'b0);

    // Unmapped read
    do_txn(32'h2000_0000, 1'b0, 32'h0);
    chk("unmap_latency", lat, 1);
    chk("unmap_error", err, 1'b1);
    chk("unmap_rdata", rdata, 32'h0);
    chk("unmap_sel_cyc", sel_cyc, 0);
    chk("unmap_err_addr", err_addr, 32'h2000_0000);
    chk("unmap_err_count", err_count, 16'd1);

    // Write to slave2 with three wait states
    wait_cfg[2] = 3;
    do_txn(32'hF000_0004, 1'b1, 32'h0000_003F);
    chk("wr2_latency", lat, 5);
    chk("wr2_sel", sel1, 4'b0100);
    chk("wr2_wdata", wdata1, 32'h0000_003F);
    chk("wr2_sel_cyc", sel_cyc, 4);
    chk("wr2_write_cyc", wr_cyc, 4);
    chk("wr2_error", err, 1'b0);
    chk("wr2_rdata", rdata, 32'h0);

    // Slave3 never ready, other slaves asserting ready
    wait_cfg[3] = 255; stray = 1'b1;
    do_txn(32'hF100_0000, 1'b0, 32'h0);
    chk("tmo_latency", lat, 16);
    chk("tmo_sel_cyc", sel_cyc, 15);
    chk("tmo_error", err, 1'b1);
    chk("tmo_rdata", rdata, 32'h0);
    chk("tmo_sel_after", sel_resp, 4'b0000);
    chk("tmo_err_addr", err_addr, 32'hF100_0000);
    chk("tmo_err_count", err_count, 16'd2);
    stray = 1'b0;

    // Just outside slave3's 8-byte window
    do_txn(32'hF100_0008, 1'b0, 32'h0);
    chk("edge3_latency", lat, 1);
    chk("edge3_error", err, 1'b1);
    chk("edge3_err_count", err_count, 16'd3);

    // Slave1 read with one wait state
    wait_cfg[1] = 1;
    do_txn(32'h0001_0020, 1'b0, 32'h0);
    chk("rd1_latency", lat, 3);
    chk("rd1_sel", sel1, 4'b0010);
    chk("rd1_rdata", rdata, 32'h11111111);

    // Reset in the middle of an access
    wait_cfg[1] = 10;
    cpu_addr = 32'h0001_0000; cpu_write = 1'b0; cpu_valid = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_sel_before", slv_sel, 4'b0010);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_ctrl", {cpu_ready, cpu_error, slv_write, slv_instr, slv_sel}, 8'h00);
    chk("rstmid_rdata", cpu_rdata, 32'h0);
    chk("rstmid_slv_addr", slv_addr, 32'h0);
    chk("rstmid_err_addr", err_addr, 32'h0);
    chk("rstmid_err_count", err_count, 16'h0);
    reset = 1'b1; cpu_valid = 1'b0;
    @(posedge clk); #1;
    do_txn(32'h0000_FFFC, 1'b0, 32'h0);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_rdata", rdata, 32'hDEADBEEF);
    chk("post_rst_error", err, 1'b0);

    // Overlapping map: lowest index wins
    o_txn(32'h0000_0100);
    chk("ovl_latency", o_lat, 2);
    chk("ovl_sel", o_sel1, 2'b01);
    chk("ovl_rdata", o_rd, 32'hAAAA0000);
    o_txn(32'h0005_0000);
    chk("ovl1_sel", o_sel1, 2'b10);
    chk("ovl1_rdata", o_rd, 32'hBBBB0001);
    chk("ovl1_error", o_er, 1'b0);

    // Error counter saturation
    for (int k = 0; k < 5; k++) begin
      o_txn(32'h1000_0000 + 32'(k * 4));
      if (k == 1) chk("sat_count_2", o_err_count, 16'd2);
      if (k == 2) chk("sat_count_3", o_err_count, 16'd3);
    end
    chk("sat_error", o_er, 1'b1);
    chk("sat_count_hold", o_err_count, 16'd3);
    chk("sat_err_addr", o_err_addr, 32'h1000_0010);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
